lmem_bank_responder: RTL and testbench

- Responder end of the per-lane local-memory bus. It is the slave that services the word requests that the LSU adapter issues toward shared memory.
- It accepts read/write word requests, holds a single-ported word SRAM, and returns read responses (and optional write acks) in order, carrying the original tag.
- It enforces credit-based flow control, so that response backpressure never drops data.
- Perf counters expose access and stall activity to the core perf path.

---
 rtl/lmem_bank_responder.sv | 140 ++++++++++++++
 tb/tb_lmem_bank_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_bank_responder.sv
// Local-memory bank responder: single-ported word SRAM behind a credit-limited,
// in-order response path that returns the request tag with each response.
module lmem_bank_responder #(
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int TAG_WIDTH    = 8,
  parameter int RSP_BUF_SIZE = 2,
  parameter bit WRITE_ACK    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0]   req_byteen,
  input  logic [8*WORD_SIZE-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [8*WORD_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_writes,
  output logic [31:0]            perf_stalls
);
  // Handshake: a request moves on a clock edge where req_valid && req_ready;
  // a response moves where rsp_valid && rsp_ready. Neither side withdraws.
  localparam int DW    = 8 * WORD_SIZE;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(RSP_BUF_SIZE + 1);
  localparam int PW    = (RSP_BUF_SIZE > 1) ? $clog2(RSP_BUF_SIZE) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RSP_BUF_SIZE);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_BUF_SIZE - 1);

  logic [DW-1:0]        mem [DEPTH];
  logic [CW-1:0]        credits;
  logic                 s1_valid;
  logic [DW-1:0]        s1_data;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [DW-1:0]        q_data [RSP_BUF_SIZE];
  logic [TAG_WIDTH-1:0] q_tag  [RSP_BUF_SIZE];
  logic [PW-1:0]        q_rd_ptr;
  logic [PW-1:0]        q_wr_ptr;
  logic [CW-1:0]        q_count;

  logic needs_credit;
  logic take_credit;
  logic wr_fire;
  logic rsp_fire;
  logic q_empty;
  logic s1_to_q;
  logic q_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready comes only from registered credits and req_rw, never from rsp_ready.
  assign needs_credit = !req_rw || WRITE_ACK;
  assign req_ready    = needs_credit ? (credits != '0) : 1'b1;
  assign take_credit  = req_valid && req_ready && needs_credit;
  assign wr_fire      = req_valid && req_ready && req_rw;

  // The queue head has priority; stage 1 bypasses straight out when the queue is empty.
  assign q_empty   = (q_count == '0);
  assign rsp_valid = !q_empty || s1_valid;
  assign rsp_data  = q_empty ? s1_data : q_data[q_rd_ptr];
  assign rsp_tag   = q_empty ? s1_tag  : q_tag[q_rd_ptr];
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign q_pop     = !q_empty && rsp_fire;
  assign s1_to_q   = s1_valid && !(q_empty && rsp_fire);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits     <= CRED_MAX;
      s1_valid    <= 1'b0;
      q_rd_ptr    <= '0;
      q_wr_ptr    <= '0;
      q_count     <= '0;
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      s1_valid <= take_credit;
      if (take_credit && !rsp_fire) begin
        credits <= credits - 1'b1;
      end else if (!take_credit && rsp_fire) begin
        credits <= credits + 1'b1;
      end
      if (s1_to_q) begin
        q_wr_ptr <= ptr_next(q_wr_ptr);
      end
      if (q_pop) begin
        q_rd_ptr <= ptr_next(q_rd_ptr);
      end
      if (s1_to_q && !q_pop) begin
        q_count <= q_count + 1'b1;
      end else if (!s1_to_q && q_pop) begin
        q_count <= q_count - 1'b1;
      end
      if (req_valid && req_ready && !req_rw) begin
        perf_reads <= perf_reads + 32'd1;
      end
      if (wr_fire) begin
        perf_writes <= perf_writes + 32'd1;
      end
      if (req_valid && !req_ready) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end

  // Data path: SRAM survives reset, and a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_fire && reset_n) begin
      for (int b = 0; b < WORD_SIZE; b++) begin
        if (req_byteen[b]) begin
          mem[req_addr][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
    if (take_credit) begin
      s1_data <= req_rw ? '0 : mem[req_addr];
      s1_tag  <= req_tag;
    end
    if (s1_to_q) begin
      q_data[q_wr_ptr] <= s1_data;
      q_tag[q_wr_ptr]  <= s1_tag;
    end
  end

  credit_ceiling: assert property (@(posedge clk) disable iff (!reset_n)
    credits <= CRED_MAX);
  credit_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(take_credit && !rsp_fire && credits == '0));
  credit_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_fire && !take_credit && credits == CRED_MAX));

endmodule

// File: tb/tb_lmem_bank_responder.sv
// Bench for lmem_bank_responder: a no-ack instance checked every cycle against a
// transaction-level model, plus a write-ack instance checked with literal values.
module tb_lmem_bank_responder;
  localparam int BUF = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [9:0]  req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_data, rsp_data, perf_reads, perf_writes, perf_stalls;
  logic [7:0]  req_tag, rsp_tag;

  logic        a_req_valid, a_req_rw, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [9:0]  a_req_addr;
  logic [3:0]  a_req_byteen;
  logic [31:0] a_req_data, a_rsp_data, a_perf_reads, a_perf_writes, a_perf_stalls;
  logic [7:0]  a_req_tag, a_rsp_tag;

  int total = 0;
  int bad   = 0;

  lmem_bank_responder #(.RSP_BUF_SIZE(BUF), .WRITE_ACK(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls));

  lmem_bank_responder #(.RSP_BUF_SIZE(BUF), .WRITE_ACK(1'b1)) dut_ack (
    .clk(clk), .reset_n(reset_n), .req_valid(a_req_valid), .req_rw(a_req_rw),
    .req_addr(a_req_addr), .req_byteen(a_req_byteen), .req_data(a_req_data),
    .req_tag(a_req_tag), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag), .rsp_ready(a_rsp_ready),
    .perf_reads(a_perf_reads), .perf_writes(a_perf_writes), .perf_stalls(a_perf_stalls));

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: outstanding responses in acceptance order, each visible
  // from the cycle after its accept; credits are whatever the queue leaves free.
  logic [31:0] model_mem [1024];
  logic [39:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  bit          model_on = 1'b0;
  logic [31:0] m_reads, m_writes, m_stalls;

  always @(negedge clk) begin
    bit exp_valid;
    bit exp_ready;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      cyc_q.delete();
      m_reads  = 0;
      m_writes = 0;
      m_stalls = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_valid = (exp_q.size() > 0) && (cyc_q[0] < cyc);
      exp_ready = req_rw || (exp_q.size() < BUF);
      chk("m_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("m_rsp_data", rsp_data, exp_q[0][31:0]);
        chk("m_rsp_tag", {24'b0, rsp_tag}, {24'b0, exp_q[0][39:32]});
      end
      chk("m_perf_reads", perf_reads, m_reads);
      chk("m_perf_writes", perf_writes, m_writes);
      chk("m_perf_stalls", perf_stalls, m_stalls);
      if (exp_valid && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (req_valid && exp_ready) begin
        if (req_rw) begin
          m_writes++;
          for (int b = 0; b < 4; b++)
            if (req_byteen[b]) model_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
        end else begin
          m_reads++;
          exp_q.push_back({req_tag, model_mem[req_addr]});
          cyc_q.push_back(cyc);
        end
      end
      if (req_valid && !exp_ready) m_stalls++;
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1 just after the accepting edge.
  task automatic send(input logic rw, input logic [9:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [7:0] tag);
    bit acc = 1'b0;
    req_valid = 1'b1; req_rw = rw; req_addr = addr;
    req_data = data; req_byteen = be; req_tag = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    chk("send_accept", {31'b0, acc}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic a_send(input logic rw, input logic [9:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [7:0] tag);
    bit acc = 1'b0;
    a_req_valid = 1'b1; a_req_rw = rw; a_req_addr = addr;
    a_req_data = data; a_req_byteen = be; a_req_tag = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = a_req_ready;
      @(posedge clk); #1;
    end
    chk("a_send_accept", {31'b0, acc}, 32'd1);
    a_req_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1; a_rsp_ready = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
    a_req_valid = 1'b0; a_req_rw = 1'b0; a_req_addr = '0; a_req_byteen = '0;
    a_req_data = '0; a_req_tag = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_perf_reads", perf_reads, 32'd0);
    chk("rst_perf_stalls", perf_stalls, 32'd0);
    chk("rst_a_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    next_cycle();

    // Full write, then read with one-cycle latency
    send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 8'h00);
    send(1'b0, 10'd5, 32'h0, 4'h0, 8'h3A);
    @(negedge clk);
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t1_rsp_tag", {24'b0, rsp_tag}, 32'h3A);
    chk("t1_perf_reads", perf_reads, 32'd1);
    chk("t1_perf_writes", perf_writes, 32'd1);
    next_cycle();

    // Partial byte-enable write
    send(1'b1, 10'd5, 32'h0000AB00, 4'h2, 8'h00);
    send(1'b0, 10'd5, 32'h0, 4'h0, 8'h3B);
    @(negedge clk);
    chk("t2_rsp_data", rsp_data, 32'hDEADABEF);
    next_cycle();

    // Read immediately after write sees the new data
    send(1'b1, 10'd7, 32'h12345678, 4'hF, 8'h00);
    send(1'b0, 10'd7, 32'h0, 4'h0, 8'h07);
    @(negedge clk);
    chk("t4_rsp_data", rsp_data, 32'h12345678);
    next_cycle();

    // Backpressure: third read waits for a credit
    for (int i = 1; i <= 3; i++) send(1'b1, 10'(i), 32'h1111_0000 + i, 4'hF, 8'h00);
    rsp_ready = 1'b0;
    send(1'b0, 10'd1, 32'h0, 4'h0, 8'h01);
    send(1'b0, 10'd2, 32'h0, 4'h0, 8'h02);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'd3; req_tag = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", {31'b0, req_ready}, 32'd0);
      chk("t3_hold_tag", {24'b0, rsp_tag}, 32'h01);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_perf_stalls", perf_stalls, 32'd3);
    chk("t3_ready_pre_fire", {31'b0, req_ready}, 32'd0);
    chk("t3_first_tag", {24'b0, rsp_tag}, 32'h01);
    next_cycle();
    @(negedge clk);
    chk("t3_ready_after_fire", {31'b0, req_ready}, 32'd1);
    chk("t3_second_tag", {24'b0, rsp_tag}, 32'h02);
    chk("t3_perf_stalls_4", perf_stalls, 32'd4);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t3_third_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t3_third_tag", {24'b0, rsp_tag}, 32'h03);
    chk("t3_third_data", rsp_data, 32'h11110003);
    next_cycle();

    // Reset with reads outstanding and a write presented during reset
    rsp_ready = 1'b0;
    send(1'b0, 10'd5, 32'h0, 4'h0, 8'h51);
    send(1'b0, 10'd2, 32'h0, 4'h0, 8'h52);
    reset_n = 1'b0;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 10'd5; req_data = 32'h0; req_byteen = 4'hF;
    next_cycle();
    reset_n = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t5_perf_reads", perf_reads, 32'd0);
    chk("t5_perf_writes", perf_writes, 32'd0);
    next_cycle();
    rsp_ready = 1'b1;
    send(1'b0, 10'd5, 32'h0, 4'h0, 8'h5A);
    @(negedge clk);
    chk("t5_mem_kept", rsp_data, 32'hDEADABEF);
    chk("t5_tag", {24'b0, rsp_tag}, 32'h5A);
    next_cycle();

    // Write-ack instance
    a_send(1'b1, 10'd9, 32'hCAFEF00D, 4'hF, 8'h11);
    @(negedge clk);
    chk("wa_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
    chk("wa_rsp_data", a_rsp_data, 32'd0);
    chk("wa_rsp_tag", {24'b0, a_rsp_tag}, 32'h11);
    next_cycle();
    a_rsp_ready = 1'b0;
    a_send(1'b1, 10'd10, 32'hA0A0A0A0, 4'hF, 8'h21);
    a_send(1'b1, 10'd11, 32'hB0B0B0B0, 4'hF, 8'h22);
    a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = 10'd12; a_req_tag = 8'h23;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wa_third_stalled", {31'b0, a_req_ready}, 32'd0);
      chk("wa_hold_tag", {24'b0, a_rsp_tag}, 32'h21);
      next_cycle();
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("wa_ready_pre_fire", {31'b0, a_req_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wa_ready_after_fire", {31'b0, a_req_ready}, 32'd1);
    chk("wa_tag_22", {24'b0, a_rsp_tag}, 32'h22);
    next_cycle();
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("wa_tag_23_valid", {31'b0, a_rsp_valid}, 32'd1);
    chk("wa_tag_23", {24'b0, a_rsp_tag}, 32'h23);
    chk("wa_data_23", a_rsp_data, 32'd0);
    next_cycle();
    a_send(1'b0, 10'd9, 32'h0, 4'h0, 8'h30);
    @(negedge clk);
    chk("wa_read_data", a_rsp_data, 32'hCAFEF00D);
    chk("wa_read_tag", {24'b0, a_rsp_tag}, 32'h30);
    chk("wa_perf_writes", a_perf_writes, 32'd4);
    chk("wa_perf_reads", a_perf_reads, 32'd1);
    chk("wa_perf_stalls", a_perf_stalls, 32'd3);
    next_cycle();

    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
